sscg_ctrl: RTL and testbench
============================

// Module: sscg_ctrl
// PURPOSE
//  Run/pause/step controller for the 16-bit rotating sequence generator.
//  Issues a one-cycle load pulse and rate-divided shift-enable pulses, and tracks bit position and frame count.
//  Counts completed 16-bit frames.
//  Sits between board push-buttons (already debounced/pulsed) and the generator's load/shift-enable inputs.
// PARAMETERS
//  DIV_CNT  25_000_000  clk cycles between shift pulses (0.5 s @ 50 MHz); legal range >= 2
//  SEQ_LEN  16          bits per frame (generator width)
//  FRAME_W  8           frame counter width
// PORTS
//  clk           in   1        system clock, 50 MHz
//  rst_n         in   1        asynchronous active-low reset
//  start         in   1        1-cycle pulse: start from IDLE / resume from PAUSE
//  pause         in   1        1-cycle pulse: RUN -> PAUSE
//  stop          in   1        1-cycle pulse: any state -> IDLE
//  step          in   1        1-cycle pulse: single shift while in PAUSE
//  one_shot      in   1        1: return to IDLE after one frame; 0: free-run
//  seq_load      out  1        generator load strobe, 1 cycle
//  seq_shift_en  out  1        generator shift enable, 1 cycle per shift
//  bit_idx       out  4        shifts completed in current frame, 0..SEQ_LEN-1
//  frame_cnt     out  FRAME_W  completed frames since last start from IDLE
//  frame_done    out  1        1-cycle pulse on the shift that completes a frame
//  busy          out  1        1 in LOAD, RUN, PAUSE
// BEHAVIOUR
//  - All outputs registered. Reset: state=IDLE; all outputs 0; divider counter 0.
//  - States: IDLE, LOAD, RUN, PAUSE. Input priority per cycle: stop > pause > start > step.
//  - IDLE:
//    - start sampled in cycle N -> LOAD.
//    - seq_load=1 in cycle N+1 only.
//    - bit_idx, frame_cnt and divider cleared in that same cycle N+1.
//  - LOAD -> RUN unconditionally after one cycle.
//  - RUN:
//    - Divider counts 0..DIV_CNT-1, then wraps.
//    - seq_shift_en=1 in the wrap cycle. The first pulse comes exactly DIV_CNT cycles after the seq_load cycle; subsequent pulses are every DIV_CNT cycles.
//  - Each shift pulse: bit_idx <= bit_idx+1.
//    - At bit_idx==SEQ_LEN-1, bit_idx wraps to 0 instead.
//    - frame_done=1 in that same cycle; frame_cnt increments, modulo 2^FRAME_W.
//    - If one_shot=1 at that cycle, next state is IDLE (outputs hold, busy=0).
//  - RUN + pause -> PAUSE: divider, bit_idx, frame_cnt frozen; no shift pulses.
//  - PAUSE + start -> RUN: divider resumes from its frozen value; no reload.
//  - PAUSE + step: seq_shift_en=1 on the next cycle, with the same bit_idx/frame_done/frame_cnt update as a RUN shift.
//    - Divider untouched.
//    - A step that completes a frame with one_shot=1 -> IDLE.
//  - stop in any state -> IDLE next cycle.
//    - No further load/shift pulses.
//    - bit_idx/frame_cnt hold until the next start.
//  - start in RUN or LOAD ignored. step outside PAUSE ignored. pause outside RUN ignored.
//  - Simultaneous start+stop in IDLE: stop wins, stay IDLE.
//  - Simultaneous pause and divider wrap in RUN: the shift pulse is still issued that cycle, then enter PAUSE.
//  - Asserting rst_n low mid-operation clears everything immediately; no pulse is completed.
//  - seq_load and seq_shift_en are never high in the same cycle.
// TESTING (DIV_CNT=4, SEQ_LEN=16, FRAME_W=8)
//  - Reset, start pulse at cycle 10:
//    - seq_load=1 at cycle 11 only.
//    - seq_shift_en at cycles 15,19,23,...
//    - bit_idx=1 after cycle 15.
//  - Free-run 16 shifts (one_shot=0):
//    - frame_done=1 coincident with the 16th shift (cycle 75).
//    - bit_idx=0 and frame_cnt=1 afterwards; 17th shift at cycle 79.
//  - one_shot=1, start:
//    - After frame_done, busy=0 and no further seq_shift_en for 100 cycles.
//    - frame_cnt=1.
//  - Pause after 3 shifts, 3 step pulses spaced 5 cycles apart:
//    - Exactly 3 seq_shift_en pulses, each 1 cycle after its step; bit_idx=6.
//    - Then start: next shift arrives DIV_CNT minus frozen divider count later.
//  - stop mid-RUN, then start: stop -> busy=0, no pulses; start -> seq_load, bit_idx=0, frame_cnt=0.
//  - rst_n low for 1 cycle mid-RUN with divider=2: all outputs 0 immediately; state IDLE after release.

Source files
------------

// File: rtl/sscg_ctrl.sv
// Run/pause/step controller for the rotating sequence generator: issues the load
// strobe and rate-divided shift enables, tracks bit position and completed frames.
module sscg_ctrl #(
  parameter  int DIV_CNT = 25_000_000,
  parameter  int SEQ_LEN = 16,
  parameter  int FRAME_W = 8,
  localparam int IDX_W   = (SEQ_LEN > 1) ? $clog2(SEQ_LEN) : 1,
  localparam int DIV_W   = (DIV_CNT > 1) ? $clog2(DIV_CNT) : 1
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               start,
  input  logic               pause,
  input  logic               stop,
  input  logic               step,
  input  logic               one_shot,
  output logic               seq_load,
  output logic               seq_shift_en,
  output logic [IDX_W-1:0]   bit_idx,
  output logic [FRAME_W-1:0] frame_cnt,
  output logic               frame_done,
  output logic               busy
);

  typedef enum logic [1:0] {S_IDLE, S_LOAD, S_RUN, S_PAUSE} state_t;

  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(DIV_CNT - 1);
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(SEQ_LEN - 1);

  state_t             r_state, w_state_nxt;
  logic [DIV_W-1:0]   r_div, w_div_nxt;
  logic [IDX_W-1:0]   w_idx_nxt;
  logic [FRAME_W-1:0] w_fcnt_nxt;
  logic               w_load_nxt, w_shift_nxt, w_done_nxt, w_busy_nxt;

  // Qualified events, with stop > pause > start > step already applied.
  logic w_start_idle, w_resume, w_pause_ok, w_step_ok;
  logic w_shift, w_frame_end, w_div_adv;

  assign w_start_idle = (r_state == S_IDLE)  && start && !stop;
  assign w_resume     = (r_state == S_PAUSE) && start && !stop;
  assign w_pause_ok   = (r_state == S_RUN)   && pause && !stop;
  assign w_step_ok    = (r_state == S_PAUSE) && step  && !stop && !start;
  assign w_shift      = ((r_state == S_RUN) && !stop && (r_div == DIV_LAST)) || w_step_ok;
  assign w_frame_end  = w_shift && (bit_idx == IDX_LAST);
  // The resume edge counts as a divider tick, so the first shift after resuming
  // lands DIV_CNT minus the frozen count after the start pulse.
  assign w_div_adv    = !stop && ((r_state == S_LOAD) || (r_state == S_RUN) || w_resume);

  // State and registered outputs
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state      <= S_IDLE;
      r_div        <= '0;
      seq_load     <= 1'b0;
      seq_shift_en <= 1'b0;
      bit_idx      <= '0;
      frame_cnt    <= '0;
      frame_done   <= 1'b0;
      busy         <= 1'b0;
    end else begin
      r_state      <= w_state_nxt;
      r_div        <= w_div_nxt;
      seq_load     <= w_load_nxt;
      seq_shift_en <= w_shift_nxt;
      bit_idx      <= w_idx_nxt;
      frame_cnt    <= w_fcnt_nxt;
      frame_done   <= w_done_nxt;
      busy         <= w_busy_nxt;
    end
  end

  // Next-state logic
  always_comb begin
    w_state_nxt = r_state;
    unique case (r_state)
      S_IDLE:  if (w_start_idle) w_state_nxt = S_LOAD;
      S_LOAD:  w_state_nxt = stop ? S_IDLE : S_RUN;
      S_RUN: begin
        if (stop)                          w_state_nxt = S_IDLE;
        else if (w_frame_end && one_shot)  w_state_nxt = S_IDLE;
        else if (w_pause_ok)               w_state_nxt = S_PAUSE;
      end
      S_PAUSE: begin
        if (stop)                          w_state_nxt = S_IDLE;
        else if (w_resume)                 w_state_nxt = S_RUN;
        else if (w_frame_end && one_shot)  w_state_nxt = S_IDLE;
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // Output / datapath next values
  always_comb begin
    w_load_nxt  = w_start_idle;
    w_shift_nxt = w_shift;
    w_done_nxt  = w_frame_end;
    w_busy_nxt  = (w_state_nxt != S_IDLE);
    w_div_nxt   = r_div;
    w_idx_nxt   = bit_idx;
    w_fcnt_nxt  = frame_cnt;

    if (w_start_idle) begin
      w_div_nxt  = '0;
      w_idx_nxt  = '0;
      w_fcnt_nxt = '0;
    end else begin
      if (w_div_adv)
        w_div_nxt = (r_div == DIV_LAST) ? '0 : r_div + 1'b1;
      if (w_shift) begin
        if (w_frame_end) begin
          w_idx_nxt  = '0;
          w_fcnt_nxt = frame_cnt + 1'b1;
        end else begin
          w_idx_nxt  = bit_idx + 1'b1;
        end
      end
    end
  end

endmodule

// File: tb/tb_sscg_ctrl.sv
// Directed bench for sscg_ctrl at DIV_CNT=4: a sparse per-cycle vector table
// plus hand sequences for one-shot completion and asynchronous reset.
module tb_sscg_ctrl;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       start = 1'b0, pause = 1'b0, stop = 1'b0, step = 1'b0, one_shot = 1'b0;
  logic       seq_load, seq_shift_en, frame_done, busy;
  logic [3:0] bit_idx;
  logic [7:0] frame_cnt;

  sscg_ctrl #(.DIV_CNT(4), .SEQ_LEN(16), .FRAME_W(8)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .pause(pause), .stop(stop),
    .step(step), .one_shot(one_shot), .seq_load(seq_load),
    .seq_shift_en(seq_shift_en), .bit_idx(bit_idx), .frame_cnt(frame_cnt),
    .frame_done(frame_done), .busy(busy)
  );

  always #5 clk = ~clk;

  // in = {start, pause, stop, step} applied in cycle c; outputs expected in cycle c
  typedef struct {
    int         c;
    logic [3:0] in;
    int         ld, sh, idx, dn, fc, bz;
  } vec_t;

  vec_t tbl[$];
  int   cyc = 0;
  int   n_chk = 0;
  int   n_err = 0;

  function automatic void add(int c, logic [3:0] in, int ld, int sh, int idx, int dn, int fc, int bz);
    vec_t v;
    v.c = c; v.in = in; v.ld = ld; v.sh = sh; v.idx = idx; v.dn = dn; v.fc = fc; v.bz = bz;
    tbl.push_back(v);
  endfunction

  task automatic chk(string nm, int act, int exp);
    n_chk++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s cyc=%0d got=%0d exp=%0d", nm, cyc, act, exp);
    end
  endtask

  task automatic chk_all(string nm, int ld, int sh, int idx, int dn, int fc, int bz);
    chk({nm, ".load"},  int'(seq_load),     ld);
    chk({nm, ".shift"}, int'(seq_shift_en), sh);
    chk({nm, ".idx"},   int'(bit_idx),      idx);
    chk({nm, ".done"},  int'(frame_done),   dn);
    chk({nm, ".fcnt"},  int'(frame_cnt),    fc);
    chk({nm, ".busy"},  int'(busy),         bz);
  endtask

  // Advance one cycle, drive this cycle's inputs, return at the falling edge
  task automatic cyc_go(logic [3:0] in);
    @(posedge clk);
    #1;
    cyc++;
    {start, pause, stop, step} = in;
    @(negedge clk);
  endtask

  initial begin
    int p, n_sh, done_cyc, n_busy;

    //        c    in       ld sh idx dn fc bz
    add( 10, 4'b1000, 0, 0,  0, 0, 0, 0);
    add( 11, 4'b0000, 1, 0,  0, 0, 0, 1);
    add( 12, 4'b0000, 0, 0,  0, 0, 0, 1);
    add( 14, 4'b0000, 0, 0,  0, 0, 0, 1);
    add( 15, 4'b0000, 0, 1,  1, 0, 0, 1);
    add( 16, 4'b0000, 0, 0,  1, 0, 0, 1);
    add( 19, 4'b0000, 0, 1,  2, 0, 0, 1);
    add( 20, 4'b1000, 0, 0,  2, 0, 0, 1);  // start in RUN ignored
    add( 21, 4'b0000, 0, 0,  2, 0, 0, 1);
    add( 23, 4'b0000, 0, 1,  3, 0, 0, 1);
    add( 32, 4'b0001, 0, 0,  5, 0, 0, 1);  // step in RUN ignored
    add( 33, 4'b0000, 0, 0,  5, 0, 0, 1);
    add( 71, 4'b0000, 0, 1, 15, 0, 0, 1);
    add( 75, 4'b0000, 0, 1,  0, 1, 1, 1);  // 16th shift closes the frame
    add( 76, 4'b0000, 0, 0,  0, 0, 1, 1);
    add( 79, 4'b0000, 0, 1,  1, 0, 1, 1);
    add( 80, 4'b0010, 0, 0,  1, 0, 1, 1);  // stop mid-RUN
    add( 81, 4'b0000, 0, 0,  1, 0, 1, 0);
    add( 83, 4'b0000, 0, 0,  1, 0, 1, 0);
    add( 85, 4'b1010, 0, 0,  1, 0, 1, 0);  // start+stop in IDLE
    add( 86, 4'b0000, 0, 0,  1, 0, 1, 0);
    add( 88, 4'b1000, 0, 0,  1, 0, 1, 0);
    add( 89, 4'b0100, 1, 0,  0, 0, 0, 1);  // pause in LOAD ignored
    add( 90, 4'b0000, 0, 0,  0, 0, 0, 1);
    add( 93, 4'b0000, 0, 1,  1, 0, 0, 1);
    add(101, 4'b0000, 0, 1,  3, 0, 0, 1);
    add(102, 4'b0100, 0, 0,  3, 0, 0, 1);  // pause with divider frozen at 2
    add(103, 4'b0000, 0, 0,  3, 0, 0, 1);
    add(105, 4'b0001, 0, 0,  3, 0, 0, 1);
    add(106, 4'b0000, 0, 1,  4, 0, 0, 1);
    add(107, 4'b0000, 0, 0,  4, 0, 0, 1);
    add(110, 4'b0001, 0, 0,  4, 0, 0, 1);
    add(111, 4'b0000, 0, 1,  5, 0, 0, 1);
    add(115, 4'b0001, 0, 0,  5, 0, 0, 1);
    add(116, 4'b0000, 0, 1,  6, 0, 0, 1);
    add(120, 4'b1000, 0, 0,  6, 0, 0, 1);  // resume
    add(121, 4'b0000, 0, 0,  6, 0, 0, 1);
    add(122, 4'b0000, 0, 1,  7, 0, 0, 1);
    add(125, 4'b0100, 0, 0,  7, 0, 0, 1);  // pause on the wrap cycle
    add(126, 4'b0000, 0, 1,  8, 0, 0, 1);
    add(130, 4'b0000, 0, 0,  8, 0, 0, 1);
    add(131, 4'b0010, 0, 0,  8, 0, 0, 1);
    add(132, 4'b0000, 0, 0,  8, 0, 0, 0);

    // Reset state
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk_all("reset", 0, 0, 0, 0, 0, 0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    cyc   = 0;

    p = 0;
    for (int c = 1; c <= 132; c++) begin
      if (p < tbl.size() && tbl[p].c == c) begin
        cyc_go(tbl[p].in);
        chk_all($sformatf("vec%0d", c), tbl[p].ld, tbl[p].sh, tbl[p].idx,
                tbl[p].dn, tbl[p].fc, tbl[p].bz);
        p++;
      end else begin
        cyc_go(4'b0000);
      end
    end

    // One-shot frame: returns to IDLE after frame_done, then stays quiet
    one_shot = 1'b1;
    while (cyc < 139) cyc_go(4'b0000);
    cyc_go(4'b1000);
    n_sh = 0;
    done_cyc = -1;
    for (int c = 141; c <= 205; c++) begin
      cyc_go(4'b0000);
      if (c == 141) chk("os_load", int'(seq_load), 1);
      if (seq_shift_en) n_sh++;
      if (frame_done && done_cyc < 0) done_cyc = cyc;
    end
    chk("os_shifts", n_sh, 16);
    chk("os_done_cyc", done_cyc, 205);
    n_sh = 0;
    n_busy = 0;
    for (int c = 0; c < 100; c++) begin
      cyc_go(4'b0000);
      if (seq_shift_en) n_sh++;
      if (busy) n_busy++;
    end
    chk("os_extra_shifts", n_sh, 0);
    chk("os_busy_cycles", n_busy, 0);
    chk("os_fcnt", int'(frame_cnt), 1);
    chk("os_idx", int'(bit_idx), 0);
    one_shot = 1'b0;

    // Asynchronous reset mid-RUN with divider at 2
    while (cyc < 319) cyc_go(4'b0000);
    cyc_go(4'b1000);
    while (cyc < 327) cyc_go(4'b0000);
    chk("pre_rst_idx", int'(bit_idx), 1);
    chk("pre_rst_busy", int'(busy), 1);
    rst_n = 1'b0;
    #1;
    chk_all("async_rst", 0, 0, 0, 0, 0, 0);
    cyc_go(4'b0000);
    rst_n = 1'b1;
    n_sh = 0;
    n_busy = 0;
    for (int c = 0; c < 10; c++) begin
      cyc_go(4'b0000);
      if (seq_shift_en || seq_load) n_sh++;
      if (busy) n_busy++;
    end
    chk("post_rst_pulses", n_sh, 0);
    chk("post_rst_busy", n_busy, 0);
    cyc_go(4'b1000);
    cyc_go(4'b0000);
    chk("post_rst_start_load", int'(seq_load), 1);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
